// File: rtl/alarm_pkg.sv
// Shared encodings and limits for the alarm controller.
// The state encoding is visible on the state output port.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RINGING = 2'b01,
        ST_SNOOZE  = 2'b10
    } state_t;

    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MM_MAX = 6'd59;
    localparam logic [5:0] SS_MAX = 6'd59;

    // Only a legal hour/minute pair may be loaded into time or alarm registers.
    function automatic logic hm_valid(input logic [4:0] h, input logic [5:0] m);
        return (h <= HH_MAX) && (m <= MM_MAX);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running divider producing a one-cycle strobe every CLK_FREQ_HZ cycles.
// clr restarts the second so a freshly loaded time gets a full second.
module sec_tick_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_FREQ_HZ - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);

    logic [DW-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (clr || (r_div == DIV_MAX)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_ONE;
        end
    end

    assign tick = (r_div == DIV_MAX);

endmodule

// File: rtl/alarm_ctrl.sv
// Time-of-day keeper with a programmable alarm and a ring/snooze/timeout sequencer.
// alarm_active is decoded from the state register and enables the breathing-LED stage.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       sec_tick,
    output logic       alarm_active,
    output logic [1:0] state
);

    localparam int RC_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int SC_W = $clog2(SNOOZE_S + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_TIMEOUT_S - 1);
    localparam logic [RC_W-1:0] RING_ONE  = RC_W'(1);
    localparam logic [SC_W-1:0] SNZ_LOAD  = SC_W'(SNOOZE_S);
    localparam logic [SC_W-1:0] SNZ_ONE   = SC_W'(1);

    logic [4:0]      r_hh;
    logic [5:0]      r_mm;
    logic [5:0]      r_ss;
    logic [4:0]      r_alm_hh;
    logic [5:0]      r_alm_mm;
    state_t          r_state;
    logic [RC_W-1:0] r_ring_cnt;
    logic [SC_W-1:0] r_snz_cnt;

    logic            w_sec_tick;
    logic            w_set_time_ok;
    logic            w_set_alarm_ok;
    logic            w_tick;
    logic            w_ss_wrap;
    logic            w_mm_wrap;
    logic [4:0]      w_nxt_hh;
    logic [5:0]      w_nxt_mm;
    logic [5:0]      w_nxt_ss;
    logic            w_match;
    state_t          w_state_nxt;
    logic [RC_W-1:0] w_ring_nxt;
    logic [SC_W-1:0] w_snz_nxt;

    assign w_set_time_ok  = set_time  & hm_valid(set_hh, set_mm);
    assign w_set_alarm_ok = set_alarm & hm_valid(set_hh, set_mm);

    sec_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_sec_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_set_time_ok),
        .tick (w_sec_tick)
    );

    // A time load in the tick cycle swallows that tick for both time and FSM.
    assign w_tick = w_sec_tick & ~w_set_time_ok;

    assign w_ss_wrap = (r_ss == SS_MAX);
    assign w_mm_wrap = (r_mm == MM_MAX);
    assign w_nxt_ss  = w_ss_wrap ? 6'd0 : (r_ss + 6'd1);
    assign w_nxt_mm  = w_ss_wrap ? (w_mm_wrap ? 6'd0 : (r_mm + 6'd1)) : r_mm;
    assign w_nxt_hh  = (w_ss_wrap && w_mm_wrap) ?
                       ((r_hh == HH_MAX) ? 5'd0 : (r_hh + 5'd1)) : r_hh;

    assign w_match = w_tick & alarm_en & (r_state == ST_IDLE) &
                     (w_nxt_hh == r_alm_hh) & (w_nxt_mm == r_alm_mm) & (w_nxt_ss == 6'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hh <= 5'd0;
            r_mm <= 6'd0;
            r_ss <= 6'd0;
        end else if (w_set_time_ok) begin
            r_hh <= set_hh;
            r_mm <= set_mm;
            r_ss <= 6'd0;
        end else if (w_tick) begin
            r_hh <= w_nxt_hh;
            r_mm <= w_nxt_mm;
            r_ss <= w_nxt_ss;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alm_hh <= 5'd0;
            r_alm_mm <= 6'd0;
        end else if (w_set_alarm_ok) begin
            r_alm_hh <= set_hh;
            r_alm_mm <= set_mm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_nxt;
            r_snz_cnt  <= w_snz_nxt;
        end
    end

    // Priority: alarm_en low, valid set_alarm, stop, snooze, then tick-driven moves.
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
        w_snz_nxt   = r_snz_cnt;
        if (!alarm_en || w_set_alarm_ok) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        w_state_nxt = ST_RINGING;
                        w_ring_nxt  = '0;
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (snooze) begin
                        w_state_nxt = ST_SNOOZE;
                        w_snz_nxt   = SNZ_LOAD;
                    end else if (w_tick) begin
                        if (r_ring_cnt == RING_LAST) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ring_nxt = r_ring_cnt + RING_ONE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_snz_cnt == SNZ_ONE) begin
                            w_state_nxt = ST_RINGING;
                            w_ring_nxt  = '0;
                        end else begin
                            w_snz_nxt = r_snz_cnt - SNZ_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign hh           = r_hh;
    assign mm           = r_mm;
    assign ss           = r_ss;
    assign sec_tick     = w_sec_tick;
    assign alarm_active = (r_state == ST_RINGING);
    assign state        = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a seconds-of-day reference model predicts every
// cycle's outputs; a monitor on the falling edge compares them against the DUT.
module tb_alarm_ctrl;

    localparam int F   = 10;
    localparam int RT  = 5;
    localparam int SN  = 3;
    localparam int DAY = 86400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_time = 1'b0;
    logic       set_alarm = 1'b0;
    logic [4:0] set_hh = 5'd0;
    logic [5:0] set_mm = 6'd0;
    logic       alarm_en = 1'b0;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       sec_tick;
    logic       alarm_active;
    logic [1:0] state;

    alarm_ctrl #(
        .CLK_FREQ_HZ(F),
        .RING_TIMEOUT_S(RT),
        .SNOOZE_S(SN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .set_time(set_time), .set_alarm(set_alarm),
        .set_hh(set_hh), .set_mm(set_mm), .alarm_en(alarm_en), .stop(stop),
        .snooze(snooze), .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick),
        .alarm_active(alarm_active), .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (time as seconds of day) ----------------
    typedef enum int {M_IDLE, M_RING, M_SNOOZE} mode_t;
    mode_t m_mode;
    int    m_tod, m_alm, m_div, m_rung, m_snz_left, m_ticks;
    bit    en_next = 1'b0;

    logic [20:0] exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "reset";

    function automatic logic [1:0] mode_code(input mode_t md);
        case (md)
            M_RING:   return 2'd1;
            M_SNOOZE: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [20:0] model_out();
        logic [4:0] h;
        logic [5:0] m, s;
        h = 5'(m_tod / 3600);
        m = 6'((m_tod / 60) % 60);
        s = 6'(m_tod % 60);
        return {h, m, s, (m_div == F - 1), (m_mode == M_RING), mode_code(m_mode)};
    endfunction

    task automatic model_reset();
        m_tod = 0; m_alm = 0; m_div = 0; m_mode = M_IDLE; m_rung = 0; m_snz_left = 0;
    endtask

    task automatic model_step();
        bit tick, ok_t, ok_a, eff, match;
        int nxt, hm;
        tick  = (m_div == F - 1);
        ok_t  = set_time && set_hh <= 23 && set_mm <= 59;
        ok_a  = set_alarm && set_hh <= 23 && set_mm <= 59;
        eff   = tick && !ok_t;
        nxt   = (m_tod + 1) % DAY;
        hm    = int'(set_hh) * 3600 + int'(set_mm) * 60;
        match = eff && alarm_en && (nxt == m_alm) && (m_mode == M_IDLE);
        if (!alarm_en || ok_a) m_mode = M_IDLE;
        else if (m_mode != M_IDLE && stop) m_mode = M_IDLE;
        else if (m_mode == M_RING && snooze) begin
            m_mode = M_SNOOZE; m_snz_left = SN;
        end else if (m_mode == M_IDLE && match) begin
            m_mode = M_RING; m_rung = 0;
        end else if (m_mode == M_RING && eff) begin
            m_rung++;
            if (m_rung == RT) m_mode = M_IDLE;
        end else if (m_mode == M_SNOOZE && eff) begin
            m_snz_left--;
            if (m_snz_left == 0) begin
                m_mode = M_RING; m_rung = 0;
            end
        end
        if (ok_t) begin
            m_tod = hm; m_div = 0;
        end else if (tick) begin
            m_tod = nxt; m_div = 0;
        end else begin
            m_div++;
        end
        if (ok_a) m_alm = hm;
        if (eff) m_ticks++;
    endtask

    // ---------------- comparison / monitor ----------------
    task automatic check(input string name, input logic [20:0] a, input logic [20:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d:%0d:%0d tick=%b active=%b state=%0d, expected %0d:%0d:%0d tick=%b active=%b state=%0d",
                     name, $time, a[20:16], a[15:10], a[9:4], a[3], a[2], a[1:0],
                     e[20:16], e[15:10], e[9:4], e[3], e[2], e[1:0]);
        end
    endtask

    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(phase, {hh, mm, ss, sec_tick, alarm_active, state}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit st, input bit sa, input int h, input int m,
                         input bit sp, input bit sz);
        @(negedge clk);
        #2;
        set_time = st; set_alarm = sa; set_hh = 5'(h); set_mm = 6'(m);
        stop = sp; snooze = sz; alarm_en = en_next;
        if (!rst_n) model_reset();
        else model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = m_ticks + n;
        while (m_ticks < target) idle(1);
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_time = 0; set_alarm = 0; stop = 0; snooze = 0;
        model_reset();
        exp_q.push_back(model_out());
        #1;
        check("async_reset", {hh, mm, ss, sec_tick, alarm_active, state}, 21'd0);
        idle(n);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic ring_from_729();
        drive(1, 0, 7, 29, 0, 0);
        wait_ticks(61);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        model_reset();
        m_ticks = 0;
        idle(3);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_step();
        exp_q.push_back(model_out());

        phase = "first_tick";   idle(25);
        phase = "wrap";         drive(1, 0, 23, 59, 0, 0); wait_ticks(60); idle(5);

        phase = "alarm_timeout";
        en_next = 1'b1;
        drive(0, 1, 7, 30, 0, 0);
        drive(1, 0, 7, 29, 0, 0);
        wait_ticks(60); wait_ticks(5); wait_ticks(10);

        phase = "snooze";
        ring_from_729();
        drive(0, 0, 0, 0, 0, 1);
        wait_ticks(3); idle(3);
        drive(0, 0, 0, 0, 1, 0);
        wait_ticks(20);

        phase = "invalid_set";
        drive(1, 0, 24, 10, 0, 0); drive(1, 0, 5, 60, 0, 0);
        drive(0, 1, 24, 0, 0, 0);  drive(0, 1, 1, 60, 0, 0);
        idle(15);

        phase = "set_on_tick";
        while (m_div != F - 1) idle(1);
        drive(1, 0, 12, 34, 0, 0);
        idle(25);

        phase = "stop_and_snooze";
        ring_from_729();
        drive(0, 0, 0, 0, 1, 1);
        wait_ticks(3);

        phase = "en_drop_snooze";
        ring_from_729();
        drive(0, 0, 0, 0, 0, 1);
        wait_ticks(1);
        en_next = 1'b0; idle(2);
        en_next = 1'b1; wait_ticks(5);

        phase = "reset_mid_ring";
        ring_from_729();
        reset_pulse(2);
        en_next = 1'b1;
        idle(12);

        phase = "random";
        drive(0, 1, 7, 30, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            en_next = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 599) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    t = (m_alm - 60 + DAY) % DAY;
                    drive(1, 0, t / 3600, (t / 60) % 60, 0, 0);
                end else begin
                    drive(1, 0, $urandom_range(0, 25), $urandom_range(0, 61), 0, 0);
                end
            end else if ($urandom_range(0, 799) == 0) begin
                drive(0, 1, $urandom_range(0, 25), $urandom_range(0, 61), 0, 0);
            end else begin
                drive(0, 0, 0, 0, ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0));
            end
        end

        phase = "drain";
        idle(1);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
